// File: rtl/seg7_pkg.sv
// Shared segment glyphs, hex decode and sizing helpers for the 7-segment scan driver.
// All glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction

  // Ceiling log2; callers pass values >= 2 so the result is at least 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg7_lz_sign.sv
// Maps a snapshot of hex digits to per-position glyphs, applying
// leading-zero blanking and minus-sign placement.
module seg7_lz_sign
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    neg,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] glyphs
);

  int   k;
  logic all_zero;

  // Locate the most-significant nonzero nibble (0 when the value is zero).
  always_comb begin
    k        = 0;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[4*i +: 4] != 4'h0) begin
        k        = i;
        all_zero = 1'b0;
      end
    end
  end

  // Significant positions decode as hex; the first leading position takes the
  // minus sign for a nonzero negative value, the rest blank or show zero.
  always_comb begin
    glyphs = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (p <= k)
        glyphs[7*p +: 7] = hex_to_seg(digits[4*p +: 4]);
      else if (neg && !all_zero && (p == k + 1))
        glyphs[7*p +: 7] = SEG_MINUS;
      else if (blank_lz)
        glyphs[7*p +: 7] = SEG_BLANK;
      else
        glyphs[7*p +: 7] = SEG_ZERO;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Self-timed multiplexed 7-segment driver: dwell counter, leftmost-first digit
// scan, once-per-frame input snapshot and registered C/AN/DP outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int DIGIT_HZ   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    neg_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              C,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_done
);

  localparam int TICKS = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = clog2(TICKS);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam bit INV = (ACTIVE_LOW == 0);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    init;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_neg;
  logic                    snap_blank;

  logic dwell_end;
  logic frame_end;
  assign dwell_end = (cnt == CNT_LAST);
  assign frame_end = dwell_end && (idx == '0);

  // On the very first cycle after reset the snapshot is still empty, so the
  // decoder looks straight at the inputs being captured; the first frame is
  // then whole instead of opening with one stale glyph.
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic                    src_neg;
  logic                    src_blank;
  assign src_digits = init ? digits_in : snap_digits;
  assign src_dp     = init ? dp_in     : snap_dp;
  assign src_neg    = init ? neg_in    : snap_neg;
  assign src_blank  = init ? blank_lz  : snap_blank;

  logic [7*NUM_DIGITS-1:0] glyphs;

  seg7_lz_sign #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_sign (
    .digits   (src_digits),
    .neg      (src_neg),
    .blank_lz (src_blank),
    .glyphs   (glyphs)
  );

  logic [6:0]            cur_glyph;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            c_al;
  logic [NUM_DIGITS-1:0] an_al;
  logic                  dp_al;

  // Pick the glyph/dp for the scanned position and apply the enable (active-low form).
  always_comb begin
    cur_glyph = SEG_BLANK;
    cur_dp    = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_glyph = glyphs[7*i +: 7];
        cur_dp    = src_dp[i];
        an_sel[i] = 1'b1;
      end
    end
    c_al  = enable ? cur_glyph : SEG_BLANK;
    an_al = enable ? ~an_sel : '1;
    dp_al = !(enable && cur_dp);
  end

  // Dwell counter and leftmost-first digit pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= IDX_LAST;
    end else begin
      cnt <= dwell_end ? '0 : cnt + CNT_W'(1);
      if (dwell_end)
        idx <= (idx == '0) ? IDX_LAST : idx - IDX_W'(1);
    end
  end

  // Frame snapshot: loads at each frame boundary and once right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init        <= 1'b1;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_neg    <= 1'b0;
      snap_blank  <= 1'b0;
    end else begin
      init <= 1'b0;
      if (init || frame_end) begin
        snap_digits <= digits_in;
        snap_dp     <= dp_in;
        snap_neg    <= neg_in;
        snap_blank  <= blank_lz;
      end
    end
  end

  // Registered pin drive with output polarity applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C          <= INV ? '0 : '1;
      AN         <= INV ? '0 : '1;
      DP         <= INV ? 1'b0 : 1'b1;
      frame_done <= 1'b0;
    end else begin
      C          <= INV ? ~c_al : c_al;
      AN         <= INV ? ~an_al : an_al;
      DP         <= INV ? ~dp_al : dp_al;
      frame_done <= frame_end && !init;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with TICKS=4, NUM_DIGITS=4, active-low pins.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        neg_in;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  C;
  logic        DP;
  logic [3:0]  AN;
  logic        frame_done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1000),
    .DIGIT_HZ   (250),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .neg_in     (neg_in),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .C          (C),
    .DP         (DP),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the 16 cycles of one frame, starting at the next falling edge.
  task automatic check_frame(input string name,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0,
                             input logic [3:0] dpm, input int change_at,
                             input logic [15:0] new_digits);
    logic [6:0] e [4];
    logic [3:0] ean;
    int p;
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == change_at) digits_in = new_digits;
      p   = 3 - i / 4;
      ean = ~(4'b0001 << p);
      check($sformatf("%s_AN_%0d", name, i), {28'b0, AN}, {28'b0, ean});
      check($sformatf("%s_C_%0d", name, i), {25'b0, C}, {25'b0, e[p]});
      check($sformatf("%s_DP_%0d", name, i), {31'b0, DP}, {31'b0, ~dpm[p]});
      check($sformatf("%s_FD_%0d", name, i), {31'b0, frame_done}, {31'b0, (i == 15)});
    end
  endtask

  // Waits (bounded) for the next frame_done pulse seen on a falling edge.
  task automatic wait_frame(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_wait_frame"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    neg_in    = 1'b0;
    blank_lz  = 1'b0;
    enable    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_AN", {28'b0, AN}, 32'hF);
    check("rst_C", {25'b0, C}, 32'h7F);
    check("rst_DP", {31'b0, DP}, 32'd1);
    check("rst_FD", {31'b0, frame_done}, 32'd0);
    reset = 1'b0;

    // 1: scan after reset release, two consecutive frames
    check_frame("t1a", S1, S2, S3, S4, 4'b0000, -1, 16'h0);
    check_frame("t1b", S1, S2, S3, S4, 4'b0000, -1, 16'h0);

    // 2: leading-zero blanking on and off
    digits_in = 16'h0042; blank_lz = 1'b1;
    wait_frame("t2a");
    check_frame("t2a", SB, SB, S4, S2, 4'b0000, -1, 16'h0);
    blank_lz = 1'b0;
    wait_frame("t2b");
    check_frame("t2b", S0, S0, S4, S2, 4'b0000, -1, 16'h0);

    // 3: minus sign placement, and dropped sign when no position is free
    neg_in = 1'b1; blank_lz = 1'b1;
    wait_frame("t3a");
    check_frame("t3a", SB, SM, S4, S2, 4'b0000, -1, 16'h0);
    digits_in = 16'h2000;
    wait_frame("t3b");
    check_frame("t3b", S2, S0, S0, S0, 4'b0000, -1, 16'h0);

    // 4: all-zero value never shows "-0"
    digits_in = 16'h0000;
    wait_frame("t4");
    check_frame("t4", SB, SB, SB, S0, 4'b0000, -1, 16'h0);

    // 5: mid-frame input change is held off until the next frame
    neg_in = 1'b0; blank_lz = 1'b0; digits_in = 16'h1111;
    wait_frame("t5a");
    check_frame("t5a", S1, S1, S1, S1, 4'b0000, 5, 16'h2222);
    check_frame("t5b", S2, S2, S2, S2, 4'b0000, -1, 16'h0);

    // 6a: decimal point on one position
    digits_in = 16'h1234; dp_in = 4'b0100;
    wait_frame("t6a");
    check_frame("t6a", S1, S2, S3, S4, 4'b0100, -1, 16'h0);

    // 6b: enable low darkens the pins while frames keep running
    enable = 1'b0;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (frame_done) pulses++;
      check($sformatf("t6b_AN_%0d", i), {28'b0, AN}, 32'hF);
      check($sformatf("t6b_C_%0d", i), {25'b0, C}, 32'h7F);
      check($sformatf("t6b_DP_%0d", i), {31'b0, DP}, 32'd1);
    end
    check("t6b_pulses", pulses, 32'd1);
    enable = 1'b1; dp_in = 4'b0000;

    // 6c: asynchronous reset at cnt=2, idx=1, then restart at the leftmost digit
    wait_frame("t6c");
    repeat (10) @(negedge clk);
    check("t6c_pre_AN", {28'b0, AN}, 32'b1101);
    reset = 1'b1;
    #1;
    check("t6c_AN", {28'b0, AN}, 32'hF);
    check("t6c_C", {25'b0, C}, 32'h7F);
    check("t6c_DP", {31'b0, DP}, 32'd1);
    check("t6c_FD", {31'b0, frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_frame("t6d", S1, S2, S3, S4, 4'b0000, -1, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
